// File: rtl/pixel_sweep_engine.sv
// Pixel sweep generator: raster-scans a full frame or a clamped box, one beat per accepted handshake.
// Latency: command accepted at edge N, first out_valid after edge N+2; one beat per cycle while out_ready.
// Backpressure: out_* held stable while out_valid && !out_ready; cmd_ready only while idle (no queueing).
module pixel_sweep_engine #(
  parameter int FRAME_WIDTH  = 512,
  parameter int FRAME_HEIGHT = 384,
  parameter int COORD_BITS   = 16,
  parameter int ADDR_BITS    = 18,
  parameter int COLOR_WIDTH  = 16,
  parameter int COUNT_BITS   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_mode,
  input  logic [COORD_BITS-1:0]  cmd_xmin,
  input  logic [COORD_BITS-1:0]  cmd_xmax,
  input  logic [COORD_BITS-1:0]  cmd_ymin,
  input  logic [COORD_BITS-1:0]  cmd_ymax,
  input  logic [COLOR_WIDTH-1:0] cmd_color,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COORD_BITS-1:0]  out_x,
  output logic [COORD_BITS-1:0]  out_y,
  output logic [ADDR_BITS-1:0]   out_addr,
  output logic [COLOR_WIDTH-1:0] out_color,
  output logic                   out_last,
  output logic                   busy,
  output logic [COUNT_BITS-1:0]  sweeps_done
);

  typedef enum logic [1:0] {IDLE, SETUP, SWEEP, DONE} state_t;

  localparam logic [COORD_BITS-1:0] X_LIM   = COORD_BITS'(FRAME_WIDTH - 1);
  localparam logic [COORD_BITS-1:0] Y_LIM   = COORD_BITS'(FRAME_HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0]  FW_ADDR = ADDR_BITS'(FRAME_WIDTH);

  state_t state, state_nxt;

  // Raw command as accepted in IDLE
  logic                   mode_q;
  logic [COORD_BITS-1:0]  xmin_q, xmax_q, ymin_q, ymax_q;
  logic [COLOR_WIDTH-1:0] color_q;

  // Clamped sweep window, prepared in SETUP
  logic [COORD_BITS-1:0]  xlo_c, xhi_c, ylo_c, yhi_c;
  logic                   empty_c;
  logic [COORD_BITS-1:0]  xlo_q, xhi_q, ylo_q, yhi_q;
  logic [ADDR_BITS-1:0]   start_q;
  logic [ADDR_BITS-1:0]   wrap_q;
  logic                   prime_q;

  // Next-beat values
  logic                   at_xend;
  logic                   beat_fire;
  logic [COORD_BITS-1:0]  nx_x, nx_y;
  logic [ADDR_BITS-1:0]   nx_addr;
  logic                   nx_last;

  // Clamp the latched command to the frame and detect an empty window
  always_comb begin
    xlo_c = '0;
    xhi_c = X_LIM;
    ylo_c = '0;
    yhi_c = Y_LIM;
    if (mode_q) begin
      xlo_c = xmin_q;
      xhi_c = (xmax_q > X_LIM) ? X_LIM : xmax_q;
      ylo_c = ymin_q;
      yhi_c = (ymax_q > Y_LIM) ? Y_LIM : ymax_q;
    end
    empty_c = (xlo_c > xhi_c) || (ylo_c > yhi_c);
  end

  // Raster step: x fastest, address stepped incrementally (wrap delta precomputed)
  always_comb begin
    beat_fire = out_valid && out_ready;
    at_xend   = (out_x == xhi_q);
    nx_x      = at_xend ? xlo_q : out_x + COORD_BITS'(1);
    nx_y      = at_xend ? out_y + COORD_BITS'(1) : out_y;
    nx_addr   = out_addr + (at_xend ? wrap_q : ADDR_BITS'(1));
    nx_last   = (nx_x == xhi_q) && (nx_y == yhi_q);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic and state-derived outputs
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = SETUP;
      end
      SETUP:   state_nxt = empty_c ? DONE : SWEEP;
      SWEEP:   if (beat_fire && out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch and SETUP-time window/address preparation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= 1'b0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      color_q <= '0;
      xlo_q   <= '0;
      xhi_q   <= '0;
      ylo_q   <= '0;
      yhi_q   <= '0;
      start_q <= '0;
      wrap_q  <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        mode_q  <= cmd_mode;
        xmin_q  <= cmd_xmin;
        xmax_q  <= cmd_xmax;
        ymin_q  <= cmd_ymin;
        ymax_q  <= cmd_ymax;
        color_q <= cmd_color;
      end
      if (state == SETUP) begin
        xlo_q   <= xlo_c;
        xhi_q   <= xhi_c;
        ylo_q   <= ylo_c;
        yhi_q   <= yhi_c;
        // The only multiply: once per sweep, off the beat path
        start_q <= ADDR_BITS'(ylo_c) * FW_ADDR + ADDR_BITS'(xlo_c);
        wrap_q  <= FW_ADDR - ADDR_BITS'(xhi_c - xlo_c);
      end
    end
  end

  // Output beat register: load first beat on SWEEP entry, advance only on handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prime_q   <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_addr  <= '0;
      out_color <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == SETUP) prime_q <= !empty_c;
      if (state == SWEEP) begin
        if (prime_q) begin
          prime_q   <= 1'b0;
          out_valid <= 1'b1;
          out_x     <= xlo_q;
          out_y     <= ylo_q;
          out_addr  <= start_q;
          out_color <= color_q;
          out_last  <= (xlo_q == xhi_q) && (ylo_q == yhi_q);
        end else if (beat_fire) begin
          if (out_last) begin
            out_valid <= 1'b0;
          end else begin
            out_x    <= nx_x;
            out_y    <= nx_y;
            out_addr <= nx_addr;
            out_last <= nx_last;
          end
        end
      end
    end
  end

  // Completed-sweep counter, bumped once per pass through DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               sweeps_done <= '0;
    else if (state == DONE) sweeps_done <= sweeps_done + COUNT_BITS'(1);
  end

endmodule

// File: doc/pixel_sweep_engine.md
Name: pixel_sweep_engine

Overview:
- Parametrised pixel-sweep generator that replaces the free-running hcount/vcount frame counter feeding triangle fill and the pixel BRAM write port.
- Accepts sweep commands over a valid/ready handshake. Each command is either a full-frame sweep or a rectangle (bounding-box) sweep clamped to the frame.
- Emits one pixel coordinate, linear BRAM address and colour per accepted beat, with backpressure, last-beat marking and a completed-sweep counter.
- Sits between rasterization_controller/triangle_3d_to_2d and triangle_2d_fill/pixel_bram write logic.

Parameters:
- FRAME_WIDTH, 512, pixels per line; any value ≥1.
- FRAME_HEIGHT, 384, lines per frame; any value ≥1.
- COORD_BITS, 16, width of x/y coordinates.
- ADDR_BITS, 18, width of linear pixel address; must satisfy 2^ADDR_BITS ≥ FRAME_WIDTH*FRAME_HEIGHT.
- COLOR_WIDTH, 16, width of padded colour.
- COUNT_BITS, 16, width of sweeps_done counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command offered
- cmd_ready  output  1  engine can accept a command
- cmd_mode  input  1  0 = full-frame sweep, 1 = box sweep
- cmd_xmin, cmd_xmax  input  COORD_BITS each  box x bounds, inclusive, unsigned
- cmd_ymin, cmd_ymax  input  COORD_BITS each  box y bounds, inclusive, unsigned
- cmd_color  input  COLOR_WIDTH  colour attached to every beat of the sweep
- out_valid  output  1  pixel beat valid
- out_ready  input  1  downstream accepts beat
- out_x, out_y  output  COORD_BITS each  pixel coordinate
- out_addr  output  ADDR_BITS  out_y*FRAME_WIDTH + out_x
- out_color  output  COLOR_WIDTH  latched cmd_color
- out_last  output  1  final beat of current sweep
- busy  output  1  state != IDLE
- sweeps_done  output  COUNT_BITS  completed sweeps, wraps modulo 2^COUNT_BITS

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs 0 except cmd_ready = 1. This includes out_valid, out_x/y/addr/color, out_last, busy and sweeps_done.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid, latch the command and go to SETUP.
  - SETUP: one cycle. Clamp the bounds, detect an empty box, compute the start address. If empty, go to DONE; otherwise go to SWEEP.
  - SWEEP: emit beats.
  - DONE: one cycle. Increment sweeps_done, then go to IDLE.
- cmd_ready = 1 only in IDLE. Commands are never queued.
- Clamping:
  - mode 0 uses x 0..FRAME_WIDTH-1 and y 0..FRAME_HEIGHT-1; box fields are ignored.
  - mode 1: xmax' = min(cmd_xmax, FRAME_WIDTH-1), ymax' = min(cmd_ymax, FRAME_HEIGHT-1).
  - Empty when cmd_xmin > xmax' or cmd_ymin > ymax'. An empty sweep emits no beats but still counts as a completed sweep.
- Latency: command accepted at edge N → first out_valid asserted after edge N+2 (the IDLE→SETUP→SWEEP path).
- Output register:
  - out_x/out_y/out_addr/out_color/out_last are registered and held stable while out_valid && !out_ready.
  - The beat advances only on out_valid && out_ready.
- Scan order: raster, x fastest. After x == xmax', x returns to xmin and y increments.
- Address is maintained incrementally with no multiplier on the beat path:
  - +1 per x step.
  - +(FRAME_WIDTH - (xmax' - xmin)) on a line wrap.
  - Start address y0*FRAME_WIDTH + x0 is computed in SETUP.
- out_last = 1 exactly on the beat with x == xmax' and y == ymax'.
- On acceptance of the last beat: out_valid drops next cycle, state goes to DONE, and sweeps_done increments at the DONE edge.
- A 1×1 box emits a single beat with out_last = 1.
- out_ready held low indefinitely stalls the engine with no beat lost or duplicated.
- out_ready may be high while out_valid is low; this has no effect.
- Reset asserted mid-sweep aborts immediately: no further beats, counter cleared, cmd_ready = 1 after release.
- Arithmetic is unsigned. Coordinate compares use COORD_BITS. Address arithmetic uses ADDR_BITS with no overflow for legal parameters.

Test Plan:
- Box 10..11 × 20..21 with colour 16'h0F0F, out_ready=1 → exactly 4 beats (10,20)@10250, (11,20)@10251, (10,21)@10762, (11,21)@10763. out_last only on the 4th beat, all beats carry colour 0F0F, sweeps_done = 1.
- Same box, out_ready toggled 1,0,0,1,... → identical beat sequence. Outputs stable during every stall cycle; beat count remains 4.
- Box x 510..600, y 383..900 → clamped to x 510..511, y 383. Exactly 2 beats at addresses 196606 and 196607; the second has out_last.
- Box xmin=20 > xmax=10 → zero beats, cmd_ready returns high, sweeps_done increments by 1.
- mode 0, out_ready=1 → 196608 beats, addresses 0..196607 contiguous. The first out_valid appears 2 cycles after acceptance, and out_last occurs only at address 196607.
- Reset pulsed low during the 100th beat of a full-frame sweep → out_valid low immediately, sweeps_done = 0. A new 1×1 box at (0,0) then produces one beat at address 0 with out_last.
